// File: rtl/nic_axi_pkg.sv
// Shared definitions for the NIC AXI4-lite register port: response codes,
// port FSM states, timeout fill data and the address range helper.
package nic_axi_pkg;

   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_SLVERR  = 2'b10;
   localparam logic [1:0]  RESP_DECERR  = 2'b11;

   // Data returned when the register file never answers a read.
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_ISSUE = 3'd1,
      ST_WR_RESP  = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_RD_RESP  = 3'd4
   } port_state_t;

   // Range check on the full 32-bit byte address; low bits take part too,
   // which is harmless because the limit is word aligned.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] limit);
      return addr < limit;
   endfunction

endpackage

// File: rtl/axi_lite_capture_slot.sv
// One-entry valid/ready holding register. Accepts a beat when enabled and
// empty, then holds it until the owner clears it.
module axi_lite_capture_slot #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         accept_en_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   input  logic         clear_i,
   output logic         ready_o,
   output logic         accept_o,
   output logic         full_o,
   output logic [W-1:0] data_o
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;

   assign ready_o  = accept_en_i & ~full_q;
   assign accept_o = ready_o & valid_i;
   assign full_o   = full_q;
   assign data_o   = data_q;

   // Next-state: clear wins over capture (the owner never does both at once).
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clear_i) begin
         full_d = 1'b0;
         data_d = '0;
      end else if (accept_o) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   // Slot register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/axi_lite_reg_port.sv
// AXI4-lite slave front end that turns single-beat transactions into a
// one-cycle write strobe and a read request/valid pair, one transaction at
// a time, with address range checking and a bounded read latency.
//
// Handshakes: every AXI channel transfers on a rising aclk edge where both
// valid and ready are high; valid never depends on ready, ready may depend
// on valid (arready drops when a complete write is presented alongside).
module axi_lite_reg_port
   import nic_axi_pkg::*;
#(
   parameter int unsigned REG_ADDR_BITS = 17,
   parameter logic [31:0] ADDR_LIMIT    = 32'h0002_0000,
   parameter int unsigned RD_TIMEOUT    = 255
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     axi_s_awvalid,
   output logic                     axi_s_awready,
   input  logic [31:0]              axi_s_awaddr,
   input  logic                     axi_s_wvalid,
   output logic                     axi_s_wready,
   input  logic [31:0]              axi_s_wdata,
   input  logic [3:0]               axi_s_wstrb,
   output logic                     axi_s_bvalid,
   input  logic                     axi_s_bready,
   output logic [1:0]               axi_s_bresp,
   input  logic                     axi_s_arvalid,
   output logic                     axi_s_arready,
   input  logic [31:0]              axi_s_araddr,
   output logic                     axi_s_rvalid,
   input  logic                     axi_s_rready,
   output logic [31:0]              axi_s_rdata,
   output logic [1:0]               axi_s_rresp,
   output logic [REG_ADDR_BITS-1:0] reg_addr,
   output logic                     reg_wen,
   output logic [31:0]              reg_wdata,
   output logic [3:0]               reg_wstrb,
   output logic                     reg_ren,
   input  logic [31:0]              reg_rdata,
   input  logic                     reg_rvalid,
   output logic [2:0]               dbg_state
);

   // Word-address bits kept per request; byte bits [1:0] are dropped.
   localparam int unsigned WA_W  = REG_ADDR_BITS - 2;
   localparam int unsigned CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);

   port_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       rresp_q, rresp_d;
   logic [1:0]       bresp_q, bresp_d;
   logic             run_q;

   logic            idle_ok;
   logic            aw_rdy, aw_hs, aw_full, aw_clr;
   logic [WA_W:0]   aw_data;
   logic            w_rdy, w_hs, w_full, w_clr;
   logic [35:0]     w_data;
   logic            ar_en, ar_rdy, ar_hs, ar_full, ar_clr;
   logic [WA_W-1:0] ar_data;
   logic            ar_in_range;
   logic            aw_in_range;

   // run_q keeps every ready low while reset is asserted and for the first
   // edge after release, so all outputs are 0 throughout reset.
   assign idle_ok = (state_q == ST_IDLE) && run_q;

   // Reads are only accepted with no write half-captured, and a complete
   // write presented in the same cycle takes precedence.
   assign ar_en       = idle_ok && !aw_full && !w_full &&
                        !(axi_s_awvalid && axi_s_wvalid);
   assign ar_in_range = addr_in_range(axi_s_araddr, ADDR_LIMIT);

   // AW slot stores the range verdict alongside the word address.
   axi_lite_capture_slot #(.W(WA_W + 1)) u_aw_slot (
      .clk         (aclk),
      .rst_n       (aresetn),
      .accept_en_i (idle_ok),
      .valid_i     (axi_s_awvalid),
      .data_i      ({addr_in_range(axi_s_awaddr, ADDR_LIMIT),
                     axi_s_awaddr[REG_ADDR_BITS-1:2]}),
      .clear_i     (aw_clr),
      .ready_o     (aw_rdy),
      .accept_o    (aw_hs),
      .full_o      (aw_full),
      .data_o      (aw_data)
   );

   axi_lite_capture_slot #(.W(36)) u_w_slot (
      .clk         (aclk),
      .rst_n       (aresetn),
      .accept_en_i (idle_ok),
      .valid_i     (axi_s_wvalid),
      .data_i      ({axi_s_wstrb, axi_s_wdata}),
      .clear_i     (w_clr),
      .ready_o     (w_rdy),
      .accept_o    (w_hs),
      .full_o      (w_full),
      .data_o      (w_data)
   );

   axi_lite_capture_slot #(.W(WA_W)) u_ar_slot (
      .clk         (aclk),
      .rst_n       (aresetn),
      .accept_en_i (ar_en),
      .valid_i     (axi_s_arvalid),
      .data_i      (axi_s_araddr[REG_ADDR_BITS-1:2]),
      .clear_i     (ar_clr),
      .ready_o     (ar_rdy),
      .accept_o    (ar_hs),
      .full_o      (ar_full),
      .data_o      (ar_data)
   );

   assign aw_in_range = aw_data[WA_W];

   // Next-state and response datapath. The write is launched on the edge
   // that completes the AW/W pair so bvalid follows two cycles later.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      bresp_d = bresp_q;
      aw_clr  = 1'b0;
      w_clr   = 1'b0;
      ar_clr  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((aw_full || aw_hs) && (w_full || w_hs)) begin
               state_d = ST_WR_ISSUE;
            end else if (ar_hs) begin
               if (ar_in_range) begin
                  state_d = ST_RD_WAIT;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_RD_RESP;
                  rdata_d = '0;
                  rresp_d = RESP_DECERR;
               end
            end
         end
         ST_WR_ISSUE: begin
            bresp_d = aw_in_range ? RESP_OKAY : RESP_DECERR;
            state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (axi_s_bready) begin
               aw_clr  = 1'b1;
               w_clr   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            // Data arriving on the timeout cycle still counts as a success.
            if (reg_rvalid) begin
               rdata_d = reg_rdata;
               rresp_d = RESP_OKAY;
               state_d = ST_RD_RESP;
            end else if (cnt_q == CNT_MAX) begin
               rdata_d = TIMEOUT_DATA;
               rresp_d = RESP_SLVERR;
               state_d = ST_RD_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RD_RESP: begin
            if (axi_s_rready) begin
               ar_clr  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, timeout counter and response registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         bresp_q <= RESP_OKAY;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         bresp_q <= bresp_d;
         run_q   <= 1'b1;
      end
   end

   assign axi_s_awready = aw_rdy;
   assign axi_s_wready  = w_rdy;
   assign axi_s_arready = ar_rdy;
   assign axi_s_bvalid  = (state_q == ST_WR_RESP);
   assign axi_s_bresp   = bresp_q;
   assign axi_s_rvalid  = (state_q == ST_RD_RESP);
   assign axi_s_rdata   = rdata_q;
   assign axi_s_rresp   = rresp_q;

   // The counter is zero only on the first RD_WAIT cycle, giving one pulse.
   assign reg_wen   = (state_q == ST_WR_ISSUE) && aw_in_range;
   assign reg_ren   = (state_q == ST_RD_WAIT) && (cnt_q == '0);
   assign reg_addr  = (state_q == ST_RD_WAIT) ? {ar_data, 2'b00}
                                              : {aw_data[WA_W-1:0], 2'b00};
   assign reg_wdata = w_data[31:0];
   assign reg_wstrb = w_data[35:32];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_lite_reg_port.sv
// Directed bench for axi_lite_reg_port: a vector table of single
// transactions plus hand-written backpressure, arbitration, timeout and
// reset sequences.
module tb_axi_lite_reg_port;
   import nic_axi_pkg::*;

   localparam int RD_TO = 255;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        axi_s_awvalid, axi_s_awready;
   logic [31:0] axi_s_awaddr;
   logic        axi_s_wvalid, axi_s_wready;
   logic [31:0] axi_s_wdata;
   logic [3:0]  axi_s_wstrb;
   logic        axi_s_bvalid, axi_s_bready;
   logic [1:0]  axi_s_bresp;
   logic        axi_s_arvalid, axi_s_arready;
   logic [31:0] axi_s_araddr;
   logic        axi_s_rvalid, axi_s_rready;
   logic [31:0] axi_s_rdata;
   logic [1:0]  axi_s_rresp;
   logic [16:0] reg_addr;
   logic        reg_wen, reg_ren, reg_rvalid;
   logic [31:0] reg_wdata, reg_rdata;
   logic [3:0]  reg_wstrb;
   logic [2:0]  dbg_state;

   axi_lite_reg_port dut (
      .aclk(aclk), .aresetn(aresetn),
      .axi_s_awvalid(axi_s_awvalid), .axi_s_awready(axi_s_awready), .axi_s_awaddr(axi_s_awaddr),
      .axi_s_wvalid(axi_s_wvalid), .axi_s_wready(axi_s_wready), .axi_s_wdata(axi_s_wdata),
      .axi_s_wstrb(axi_s_wstrb), .axi_s_bvalid(axi_s_bvalid), .axi_s_bready(axi_s_bready),
      .axi_s_bresp(axi_s_bresp), .axi_s_arvalid(axi_s_arvalid), .axi_s_arready(axi_s_arready),
      .axi_s_araddr(axi_s_araddr), .axi_s_rvalid(axi_s_rvalid), .axi_s_rready(axi_s_rready),
      .axi_s_rdata(axi_s_rdata), .axi_s_rresp(axi_s_rresp), .reg_addr(reg_addr),
      .reg_wen(reg_wen), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_ren(reg_ren),
      .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .dbg_state(dbg_state)
   );

   // Clock
   initial forever #5 aclk = ~aclk;

   int tests = 0;
   int failed = 0;

   // Strobe monitor: counts pulses and records the bus contents of the last one.
   int          wen_cnt = 0, ren_cnt = 0;
   logic [16:0] wen_addr = '0, ren_addr = '0;
   logic [31:0] wen_data = '0;
   logic [3:0]  wen_strb = '0;
   initial forever begin
      @(negedge aclk);
      if (reg_wen === 1'b1) begin
         wen_cnt++; wen_addr = reg_addr; wen_data = reg_wdata; wen_strb = reg_wstrb;
      end
      if (reg_ren === 1'b1) begin
         ren_cnt++; ren_addr = reg_addr;
      end
   end

   // Register file model: answers model_lat cycles after reg_ren; <=0 never answers.
   int          model_lat = 0;
   logic [31:0] model_rdata = '0;
   initial begin
      reg_rvalid = 1'b0;
      reg_rdata  = '0;
      forever begin
         @(negedge aclk);
         if (reg_ren === 1'b1 && model_lat > 0) begin
            repeat (model_lat) @(posedge aclk);
            #1;
            reg_rvalid = 1'b1; reg_rdata = model_rdata;
            @(posedge aclk); #1;
            reg_rvalid = 1'b0; reg_rdata = '0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      tests++;
      failed++;
      $display("FAIL %s: no handshake within cycle budget", name);
   endtask

   task automatic tick();
      @(posedge aclk); #1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_axi"}, {23'd0, axi_s_awready, axi_s_wready, axi_s_bvalid, axi_s_bresp,
            axi_s_arready, axi_s_rvalid, axi_s_rresp, axi_s_rdata}, 64'd0);
      check({name, "_reg"}, {9'd0, reg_addr, reg_wen, reg_ren, reg_wstrb, reg_wdata}, 64'd0);
      check({name, "_state"}, {61'd0, dbg_state}, 64'd0);
   endtask

   task automatic send_aw(input logic [31:0] a);
      bit done = 0;
      axi_s_awaddr = a; axi_s_awvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge aclk); done = axi_s_awready; tick();
      end
      axi_s_awvalid = 1'b0;
      if (!done) bound_fail("aw_handshake");
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      bit done = 0;
      axi_s_wdata = d; axi_s_wstrb = s; axi_s_wvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge aclk); done = axi_s_wready; tick();
      end
      axi_s_wvalid = 1'b0;
      if (!done) bound_fail("w_handshake");
   endtask

   task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done = 0, w_done = 0;
      axi_s_awaddr = a; axi_s_wdata = d; axi_s_wstrb = s;
      axi_s_awvalid = 1'b1; axi_s_wvalid = 1'b1;
      for (int i = 0; i < 100 && !(aw_done && w_done); i++) begin
         @(negedge aclk);
         if (axi_s_awvalid && axi_s_awready) aw_done = 1;
         if (axi_s_wvalid && axi_s_wready) w_done = 1;
         tick();
         if (aw_done) axi_s_awvalid = 1'b0;
         if (w_done) axi_s_wvalid = 1'b0;
      end
      axi_s_awvalid = 1'b0; axi_s_wvalid = 1'b0;
      if (!(aw_done && w_done)) bound_fail("aw_w_handshake");
   endtask

   task automatic send_ar(input logic [31:0] a);
      bit done = 0;
      axi_s_araddr = a; axi_s_arvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge aclk); done = axi_s_arready; tick();
      end
      axi_s_arvalid = 1'b0;
      if (!done) bound_fail("ar_handshake");
   endtask

   // Latency counts cycles after the handshake edge (1 = very next cycle).
   task automatic wait_b(output logic [1:0] resp, output int lat, input int budget);
      bit seen = 0;
      resp = '0; lat = -1;
      for (int i = 1; i <= budget && !seen; i++) begin
         @(negedge aclk);
         if (axi_s_bvalid) begin seen = 1; lat = i; resp = axi_s_bresp; end
      end
      if (!seen) bound_fail("b_wait");
      else if (axi_s_bready) tick();
   endtask

   task automatic wait_r(output logic [1:0] resp, output logic [31:0] data, output int lat,
                         input int budget);
      bit seen = 0;
      resp = '0; data = '0; lat = -1;
      for (int i = 1; i <= budget && !seen; i++) begin
         @(negedge aclk);
         if (axi_s_rvalid) begin seen = 1; lat = i; resp = axi_s_rresp; data = axi_s_rdata; end
      end
      if (!seen) bound_fail("r_wait");
      else if (axi_s_rready) tick();
   endtask

   typedef struct {
      bit          is_rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          order;      // 0: AW then W, 1: W then AW, 2: same cycle
      int          rd_lat;
      logic [31:0] model_data;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_pulses;
      logic [16:0] exp_reg_addr;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      int          lat, wb, rb, stable, cnt;
      bit          done;

      axi_s_awvalid = 0; axi_s_awaddr = 0; axi_s_wvalid = 0; axi_s_wdata = 0; axi_s_wstrb = 0;
      axi_s_arvalid = 0; axi_s_araddr = 0; axi_s_bready = 1; axi_s_rready = 1;
      aresetn = 1'b1;
      #1 aresetn = 1'b0;

      //            rd  addr           wdata          strb  ord lat model         resp rdata          lat pul reg_addr
      vecs[0] = '{1'b0, 32'h0000_0008, 32'h1234_5678, 4'hF, 0, 0, 32'h0,         2'd0, 32'h0,         2, 1, 17'h00008};
      vecs[1] = '{1'b0, 32'h0000_0008, 32'h1234_5678, 4'hF, 1, 0, 32'h0,         2'd0, 32'h0,         2, 1, 17'h00008};
      vecs[2] = '{1'b0, 32'h0000_0008, 32'h1234_5678, 4'hF, 2, 0, 32'h0,         2'd0, 32'h0,         2, 1, 17'h00008};
      vecs[3] = '{1'b0, 32'h0001_FFFF, 32'hA5A5_5A5A, 4'h3, 2, 0, 32'h0,         2'd0, 32'h0,         2, 1, 17'h1FFFC};
      vecs[4] = '{1'b0, 32'h0002_0000, 32'h1111_2222, 4'hF, 0, 0, 32'h0,         2'd3, 32'h0,         2, 0, 17'h0};
      vecs[5] = '{1'b0, 32'h8001_0004, 32'h3333_4444, 4'hF, 2, 0, 32'h0,         2'd3, 32'h0,         2, 0, 17'h0};
      vecs[6] = '{1'b1, 32'h0000_00C0, 32'h0,         4'h0, 0, 3, 32'hCAFE_0001, 2'd0, 32'hCAFE_0001, 5, 1, 17'h000C0};
      vecs[7] = '{1'b1, 32'h0003_FFFC, 32'h0,         4'h0, 0, 1, 32'h9999_9999, 2'd3, 32'h0,         1, 0, 17'h0};
      vecs[8] = '{1'b1, 32'h0000_1006, 32'h0,         4'h0, 0, 1, 32'h0BAD_F00D, 2'd0, 32'h0BAD_F00D, 3, 1, 17'h01004};
      vecs[9] = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 0, 1, 32'h9999_9999, 2'd3, 32'h0,         1, 0, 17'h0};

      repeat (3) tick();
      check_all_zero("reset");
      aresetn = 1'b1;
      repeat (2) tick();

      // Table-driven single transactions
      for (int i = 0; i < NV; i++) begin
         wb = wen_cnt; rb = ren_cnt;
         model_lat = vecs[i].rd_lat; model_rdata = vecs[i].model_data;
         if (!vecs[i].is_rd) begin
            case (vecs[i].order)
               0: begin send_aw(vecs[i].addr); tick(); send_w(vecs[i].wdata, vecs[i].wstrb); end
               1: begin send_w(vecs[i].wdata, vecs[i].wstrb); tick(); send_aw(vecs[i].addr); end
               default: send_aw_w(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            endcase
            wait_b(resp, lat, 20);
         end else begin
            send_ar(vecs[i].addr);
            wait_r(resp, data, lat, 20);
            check($sformatf("v%0d_rdata", i), data, vecs[i].exp_rdata);
         end
         repeat (2) tick();
         check($sformatf("v%0d_resp", i), resp, vecs[i].exp_resp);
         check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         if (!vecs[i].is_rd) begin
            check($sformatf("v%0d_wen_pulses", i), wen_cnt - wb, vecs[i].exp_pulses);
            check($sformatf("v%0d_ren_pulses", i), ren_cnt - rb, 0);
            if (vecs[i].exp_pulses == 1)
               check($sformatf("v%0d_wbus", i), {wen_addr, wen_strb, wen_data},
                     {vecs[i].exp_reg_addr, vecs[i].wstrb, vecs[i].wdata});
         end else begin
            check($sformatf("v%0d_ren_pulses", i), ren_cnt - rb, vecs[i].exp_pulses);
            check($sformatf("v%0d_wen_pulses", i), wen_cnt - wb, 0);
            if (vecs[i].exp_pulses == 1)
               check($sformatf("v%0d_ren_addr", i), ren_addr, vecs[i].exp_reg_addr);
         end
      end

      // Read timeout, then a normal read afterwards
      rb = ren_cnt; model_lat = -1;
      send_ar(32'h0000_0010);
      wait_r(resp, data, lat, 400);
      check("to_latency", lat, RD_TO + 2);
      check("to_rdata", data, 32'hDEAD_BEEF);
      check("to_rresp", resp, 2'd2);
      check("to_ren_pulses", ren_cnt - rb, 1);
      model_lat = 1; model_rdata = 32'h2468_ACE0;
      send_ar(32'h0000_0014);
      wait_r(resp, data, lat, 20);
      check("after_to_rdata", data, 32'h2468_ACE0);
      check("after_to_rresp", resp, 2'd0);

      // Write response backpressure
      axi_s_bready = 1'b0;
      send_aw_w(32'h0000_0020, 32'h0F0F_0F0F, 4'hF);
      wait_b(resp, lat, 20);
      check("bp_w_latency", lat, 2);
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         if (axi_s_bvalid === 1'b1 && axi_s_bresp === 2'd0 && axi_s_awready === 1'b0 &&
             axi_s_wready === 1'b0 && axi_s_arready === 1'b0) stable++;
      end
      check("bp_w_stable_cycles", stable, 10);
      axi_s_bready = 1'b1;
      tick();
      check("bp_w_released", axi_s_bvalid, 1'b0);

      // Read data backpressure
      axi_s_rready = 1'b0; model_lat = 2; model_rdata = 32'h55AA_33CC;
      send_ar(32'h0000_0040);
      wait_r(resp, data, lat, 20);
      check("bp_r_latency", lat, 4);
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         if (axi_s_rvalid === 1'b1 && axi_s_rdata === 32'h55AA_33CC && axi_s_rresp === 2'd0 &&
             axi_s_arready === 1'b0 && axi_s_awready === 1'b0) stable++;
      end
      check("bp_r_stable_cycles", stable, 10);
      axi_s_rready = 1'b1;
      tick();
      check("bp_r_released", axi_s_rvalid, 1'b0);

      // AR and a complete write presented together: write goes first
      wb = wen_cnt; rb = ren_cnt; model_lat = 1; model_rdata = 32'h1357_9BDF;
      axi_s_awaddr = 32'h0000_0030; axi_s_wdata = 32'hFACE_0030; axi_s_wstrb = 4'hC;
      axi_s_araddr = 32'h0000_0034;
      axi_s_awvalid = 1'b1; axi_s_wvalid = 1'b1; axi_s_arvalid = 1'b1;
      @(negedge aclk);
      check("sim_arready_blocked", axi_s_arready, 1'b0);
      check("sim_aw_w_ready", {axi_s_awready, axi_s_wready}, 2'b11);
      tick();
      axi_s_awvalid = 1'b0; axi_s_wvalid = 1'b0;
      wait_b(resp, lat, 10);
      check("sim_b_latency", lat, 2);
      check("sim_no_read_before_b", ren_cnt - rb, 0);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge aclk); done = axi_s_arready; tick();
      end
      axi_s_arvalid = 1'b0;
      if (!done) bound_fail("sim_ar_handshake");
      wait_r(resp, data, lat, 20);
      check("sim_rdata", data, 32'h1357_9BDF);
      check("sim_wbus", {wen_cnt - wb, wen_addr, wen_strb}, {32'd1, 17'h00030, 4'hC});
      check("sim_ren_addr", ren_addr, 17'h00034);

      // Reset during RD_WAIT
      model_lat = -1;
      send_ar(32'h0000_0050);
      repeat (5) tick();
      check("midrst_pre_state", dbg_state, ST_RD_WAIT);
      aresetn = 1'b0;
      #1;
      check_all_zero("midrst");
      repeat (2) tick();
      aresetn = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (axi_s_rvalid !== 1'b0) cnt++;
      end
      check("midrst_no_stale_rvalid", cnt, 0);
      tick();
      model_lat = 2; model_rdata = 32'h7777_0001;
      send_ar(32'h0000_0060);
      wait_r(resp, data, lat, 20);
      check("midrst_fresh_rdata", data, 32'h7777_0001);
      check("midrst_fresh_rresp", resp, 2'd0);
      check("midrst_fresh_latency", lat, 4);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Global time limit
   initial begin
      #2_000_000;
      failed++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
